// File: rtl/sumador_serial_32b_pkg.sv
// Shared types for the byte-serial adder.
// FSM state encoding and default operand width.
package sumador_serial_32b_pkg;

  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sumador_byte.sv
// 8-bit ripple-carry adder slice.
// Exposes the carry into bit 7 for signed overflow.
module sumador_byte (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_c,
  output logic [7:0] o_s,
  output logic       o_c,
  output logic       o_c7
);

  logic cy;

  // Ripple the carry through eight full adders.
  always_comb begin
    cy   = i_c;
    o_s  = '0;
    o_c7 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 7) o_c7 = cy;
      o_s[k] = i_a[k] ^ i_b[k] ^ cy;
      cy     = (i_a[k] & i_b[k]) |
               (cy & (i_a[k] ^ i_b[k]));
    end
    o_c = cy;
  end

endmodule

// File: rtl/sumador_serial_32b.sv
// Byte-serial adder, LSB byte first.
// One 8-bit slice reused over NBYTES cycles.
module sumador_serial_32b
  import sumador_serial_32b_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [8*NBYTES-1:0]   i_a,
  input  logic [8*NBYTES-1:0]   i_b,
  input  logic                  i_carry,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [8*NBYTES-1:0]   o_suma,
  output logic                  o_carry,
  output logic                  o_overflow
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   work_q, work_d;
  logic [W-1:0]   suma_q, suma_d;
  logic           cy_q, cy_d;
  logic           co_q, co_d;
  logic           ov_q, ov_d;

  logic [7:0]     byte_a, byte_b, byte_s;
  logic           byte_c, byte_c7;

  assign byte_a = a_q[{idx_q, 3'b000} +: 8];
  assign byte_b = b_q[{idx_q, 3'b000} +: 8];

  sumador_byte u_byte (
    .i_a  (byte_a),
    .i_b  (byte_b),
    .i_c  (cy_q),
    .o_s  (byte_s),
    .o_c  (byte_c),
    .o_c7 (byte_c7)
  );

  // State, operand, working and result registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      suma_q  <= '0;
      cy_q    <= 1'b0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      suma_q  <= suma_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
    end
  end

  // Next-state: accept, step one byte, publish on the last byte.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    suma_d  = suma_q;
    cy_d    = cy_q;
    co_d    = co_q;
    ov_d    = ov_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (i_start && !i_abort) begin
          state_d = ADD;
          a_d     = i_a;
          b_d     = i_b;
          cy_d    = i_carry;
          idx_d   = '0;
          work_d  = '0;
        end
      end
      ADD: begin
        if (i_abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          work_d[{idx_q, 3'b000} +: 8] = byte_s;
          cy_d  = byte_c;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_d = DONE;
            idx_d   = '0;
            suma_d  = work_d;
            co_d    = byte_c;
            ov_d    = byte_c ^ byte_c7;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign o_busy     = (state_q == ADD);
  assign o_done     = (state_q == DONE);
  assign o_suma     = suma_q;
  assign o_carry    = co_q;
  assign o_overflow = ov_q;

endmodule

// File: tb/tb_sumador_serial_32b.sv
// Bench for the byte-serial adder.
// Transaction-level model plus directed literal cases.
module tb_sumador_serial_32b;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic         i_carry = 1'b0;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         o_busy, o_done, o_carry, o_overflow;
  logic [W-1:0] o_suma;

  int checks = 0;
  int failures = 0;

  sumador_serial_32b #(.NBYTES(NB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_a        (i_a),
    .i_b        (i_b),
    .i_carry    (i_carry),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_suma     (o_suma),
    .o_carry    (o_carry),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h",
               n, act, exp);
    end
  endtask

  // Model: cycles left in the running op, DONE flag,
  // result computed with plain wide arithmetic.
  int           m_cnt = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_suma = '0;
  logic         m_co = 1'b0;
  logic         m_ov = 1'b0;
  logic [W-1:0] p_suma = '0;
  logic         p_co = 1'b0;
  logic         p_ov = 1'b0;
  logic [W:0]   full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_suma = '0;
      m_co   = 1'b0;
      m_ov   = 1'b0;
    end else if (m_cnt != 0) begin
      if (i_abort) m_cnt = 0;
      else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_suma = p_suma;
          m_co   = p_co;
          m_ov   = p_ov;
        end
      end
    end else begin
      m_done = 1'b0;
      if (i_start && !i_abort) begin
        full = {1'b0, i_a} + {1'b0, i_b}
             + {{W{1'b0}}, i_carry};
        p_suma = full[W-1:0];
        p_co   = full[W];
        p_ov   = (i_a[W-1] == i_b[W-1]) &&
                 (full[W-1] != i_a[W-1]);
        m_cnt  = NB;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", o_busy, m_cnt != 0);
    chk("done", o_done, m_done);
    chk("suma", o_suma, m_suma);
    chk("carry", o_carry, m_co);
    chk("ovf", o_overflow, m_ov);
  end

  task automatic op(input logic [W-1:0] a,
                    input logic [W-1:0] b,
                    input logic c,
                    output int lat);
    i_a = a; i_b = b; i_carry = c; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    lat = 1;
    while (o_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic res(input string n,
                     input logic [W-1:0] s,
                     input logic c, input logic v);
    chk({n, "_suma"}, o_suma, s);
    chk({n, "_carry"}, o_carry, c);
    chk({n, "_ovf"}, o_overflow, v);
  endtask

  initial begin
    int lat;
    int dones;
    int gap;

    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    res("rst", 32'h0, 1'b0, 1'b0);

    @(negedge clk);
    #2 rst_n = 1'b1;
    op(32'hFFFFFFFF, 32'h00000001, 1'b0, lat);
    chk("t36_lat", lat, 5);
    res("t36", 32'h00000000, 1'b1, 1'b0);

    @(negedge clk);
    op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
    chk("t37_lat", lat, 5);
    res("t37", 32'h80000000, 1'b0, 1'b1);

    @(negedge clk);
    op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, lat);
    res("ff_ff_c", 32'hFFFFFFFF, 1'b1, 1'b0);

    @(negedge clk);
    op(32'h80000000, 32'h80000000, 1'b0, lat);
    res("neg_ovf", 32'h00000000, 1'b1, 1'b1);

    @(negedge clk);
    i_a = 32'h12345678; i_b = 32'h11111111;
    i_carry = 1'b1; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    i_a = 32'hDEADBEEF; i_b = 32'h01010101;
    i_carry = 1'b0; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    lat = 3;
    while (o_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t38_lat", lat, 5);
    res("t38", 32'h2345678A, 1'b0, 1'b0);
    @(negedge clk);
    chk("t38_idle", o_busy, 0);

    @(negedge clk);
    i_a = 32'h00000F00; i_b = 32'h000000F0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t39_busy", o_busy, 0);
    chk("t39_done", o_done, 0);
    res("t39", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    chk("t39_nodone", dones, 0);

    op(32'h00000002, 32'h00000003, 1'b0, lat);
    res("t40_pre", 32'h00000005, 1'b0, 1'b0);
    @(negedge clk);
    i_a = 32'hAAAAAAAA; i_b = 32'h55555555;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("t40_busy", o_busy, 0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (o_done) dones++;
    end
    chk("t40_nodone", dones, 0);
    chk("t40_suma", o_suma, 32'h00000005);

    i_start = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    chk("abort_wins", o_busy, 0);

    @(negedge clk);
    i_a = 32'h10; i_b = 32'h20; i_carry = 1'b0;
    i_start = 1'b1;
    lat = 0;
    while (o_done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t41_first", o_suma, 32'h30);
    i_a = 32'hFFFF0000; i_b = 32'h0000FFFF;
    i_carry = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    chk("t41_nogap", o_busy, 1);
    chk("t41_split", o_done, 0);
    gap = 1;
    while (o_done !== 1'b1 && gap < 20) begin
      @(negedge clk);
      if (o_busy) gap++;
    end
    chk("t41_gap", gap, 4);
    res("t41", 32'h00000000, 1'b1, 1'b0);

    repeat (600) begin
      @(negedge clk);
      i_start = ($urandom_range(0, 2) == 0);
      i_abort = ($urandom_range(0, 11) == 0);
      i_a     = $urandom;
      i_b     = $urandom;
      i_carry = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
